// File: rtl/led_seq_if.sv
// led_seq_if: sequencer pins; master drives btn (active-low) and mode, slave drives led and busy
interface led_seq_if #(parameter int N_LED = 4);
  logic btn;
  logic [1:0] mode;
  logic [N_LED-1:0] led;
  logic busy;
  modport master (output btn, mode, input led, busy);
  modport slave (input btn, mode, output led, busy);
endinterface

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: debounced push-button LED pattern sequencer; ports clk, reset (async high), io.slave (btn, mode in; led, busy out)
module led_seq_ctrl #(
  parameter int N_LED = 4,
  parameter int INIT_CYCLES = 250_000_000,
  parameter int RUN_CYCLES = 250_000_000,
  parameter int HALF_PERIOD = 16_666_667,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int RETRIGGER = 1
) (
  input logic clk,
  input logic reset,
  led_seq_if.slave io
);
  localparam int MAXC = INIT_CYCLES > RUN_CYCLES ? INIT_CYCLES : RUN_CYCLES;
  localparam int RW = MAXC > 1 ? $clog2(MAXC) : 1;
  localparam int TW = HALF_PERIOD > 1 ? $clog2(HALF_PERIOD) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [RW-1:0] INIT_LAST = RW'(INIT_CYCLES - 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(RUN_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(HALF_PERIOD - 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [N_LED-1:0] ALL_ON = '1;
  localparam logic [N_LED-1:0] ALT = N_LED'({16{2'b01}});
  typedef enum logic [1:0] {INIT, IDLE, RUN} state_t;
  state_t state, state_n;
  logic [1:0] sync;
  logic btn_db, db_prev, press;
  logic [DW-1:0] db_cnt;
  logic [RW-1:0] run_cnt, run_cnt_n;
  logic [TW-1:0] tick_cnt, tick_cnt_n;
  logic [N_LED-1:0] tick_count, tick_count_n, led, led_n;
  logic [1:0] mode_q, mode_n;
  logic busy, busy_n, start, tick;
  function automatic logic [N_LED-1:0] entry(logic [1:0] m);
    return m == 2'd1 ? ~N_LED'(1) : m == 2'd2 ? ALT : ALL_ON;
  endfunction
  function automatic logic [N_LED-1:0] step(logic [1:0] m, logic [N_LED-1:0] l, logic [N_LED-1:0] tc);
    return m == 2'd3 ? ~tc : m == 2'd1 ? (l << 1) | (l >> (N_LED - 1)) : ~l;
  endfunction
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync <= 2'b11;
      btn_db <= 1'b1;
      db_prev <= 1'b1;
      db_cnt <= '0;
      press <= 1'b0;
    end else begin
      sync <= {sync[0], io.btn};
      db_prev <= btn_db;
      press <= db_prev & ~btn_db;
      if (sync[1] == btn_db)
        db_cnt <= '0;
      else if (db_cnt == DB_LAST) begin
        btn_db <= sync[1];
        db_cnt <= '0;
      end else
        db_cnt <= db_cnt + 1'b1;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= INIT;
      run_cnt <= '0;
      tick_cnt <= '0;
      tick_count <= '0;
      mode_q <= '0;
      led <= ALL_ON;
      busy <= 1'b1;
    end else begin
      state <= state_n;
      run_cnt <= run_cnt_n;
      tick_cnt <= tick_cnt_n;
      tick_count <= tick_count_n;
      mode_q <= mode_n;
      led <= led_n;
      busy <= busy_n;
    end
  assign start = press && (state == IDLE || (state == RUN && RETRIGGER != 0));
  assign tick = tick_cnt == TICK_LAST;
  always_comb begin
    state_n = state;
    run_cnt_n = run_cnt;
    tick_cnt_n = tick_cnt;
    tick_count_n = tick_count;
    mode_n = mode_q;
    led_n = led;
    busy_n = busy;
    if (start) begin
      state_n = RUN;
      run_cnt_n = '0;
      tick_cnt_n = '0;
      tick_count_n = '0;
      mode_n = io.mode;
      led_n = entry(io.mode);
      busy_n = 1'b1;
    end else if (state == INIT || state == RUN) begin
      run_cnt_n = run_cnt + 1'b1;
      if (run_cnt == (state == INIT ? INIT_LAST : RUN_LAST)) begin
        state_n = IDLE;
        run_cnt_n = '0;
        tick_cnt_n = '0;
        led_n = ALL_ON;
        busy_n = 1'b0;
      end else if (state == RUN) begin
        tick_cnt_n = tick ? '0 : tick_cnt + 1'b1;
        tick_count_n = tick ? tick_count + 1'b1 : tick_count;
        led_n = tick ? step(mode_q, led, tick_count_n) : led;
      end
    end
  end
  assign io.led = led;
  assign io.busy = busy;
endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: randomized self-checking bench for led_seq_ctrl against a cycle-count pattern model
module tb_led_seq_ctrl;
  localparam int N = 4, INIT = 20, RUN = 40, HP = 5, DB = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int tests = 0, failed = 0;
  led_seq_if #(.N_LED(N)) io ();
  led_seq_ctrl #(.N_LED(N), .INIT_CYCLES(INIT), .RUN_CYCLES(RUN), .HALF_PERIOD(HP),
                 .DEBOUNCE_CYCLES(DB), .RETRIGGER(1)) dut (.clk(clk), .reset(reset), .io(io));
  always #5 clk = ~clk;
  function automatic logic [N-1:0] exp_led(int m, int k);
    int s;
    s = k / HP;
    case (m)
      0: return (s % 2) != 0 ? 4'h0 : 4'hF;
      1: return ~(4'b0001 << (s % 4));
      2: return (s % 2) != 0 ? 4'b1010 : 4'b0101;
      default: return ~4'(s % 16);
    endcase
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic press(int m);
    io.mode = 2'(m);
    io.btn = 1'b0;
    repeat (DB + 4) tick();
  endtask
  task automatic test_reset();
    io.btn = 1'b1;
    io.mode = 2'd0;
    #2 reset = 1'b1;
    #1;
    tests++;
    if (io.led !== 4'hF || io.busy !== 1'b1) begin
      failed++;
      $display("FAIL reset led=%b busy=%b expected led=1111 busy=1", io.led, io.busy);
    end
    tick();
    tick();
    reset = 1'b0;
    io.btn = 1'b0;
    for (int k = 1; k <= INIT + 10; k++) begin
      if (k == 9) io.btn = 1'b1;
      tick();
      tests++;
      if (io.led !== 4'hF || io.busy !== (k < INIT)) begin
        failed++;
        $display("FAIL init k=%0d led=%b busy=%b expected led=1111 busy=%b", k, io.led, io.busy, k < INIT);
      end
    end
  endtask
  task automatic test_press_latency();
    logic [N-1:0] e;
    io.mode = 2'd0;
    io.btn = 1'b0;
    for (int i = 1; i <= DB + 4; i++) begin
      tick();
      tests++;
      if (io.busy !== (i == DB + 4)) begin
        failed++;
        $display("FAIL latency cycle=%0d busy=%b expected %b", i, io.busy, i == DB + 4);
      end
    end
    tests++;
    if (io.led !== 4'hF) begin
      failed++;
      $display("FAIL blink_entry led=%b expected 1111", io.led);
    end
    for (int k = 1; k <= RUN + 3; k++) begin
      if (k == 2) io.btn = 1'b1;
      tick();
      e = k < RUN ? exp_led(0, k) : 4'hF;
      tests++;
      if (io.led !== e || io.busy !== (k < RUN)) begin
        failed++;
        $display("FAIL blink k=%0d led=%b busy=%b expected led=%b busy=%b", k, io.led, io.busy, e, k < RUN);
      end
    end
  endtask
  task automatic test_patterns();
    logic [N-1:0] e;
    for (int r = 0; r < 8; r++) begin
      int m, flip;
      m = r < 4 ? r : int'($urandom_range(0, 3));
      flip = int'($urandom_range(1, RUN - 1));
      press(m);
      io.btn = 1'b1;
      tests++;
      if (io.led !== exp_led(m, 0) || io.busy !== 1'b1) begin
        failed++;
        $display("FAIL pattern_entry m=%0d led=%b busy=%b expected led=%b busy=1", m, io.led, io.busy, exp_led(m, 0));
      end
      for (int k = 1; k <= RUN + 3; k++) begin
        if (k == flip) io.mode = 2'($urandom);
        tick();
        e = k < RUN ? exp_led(m, k) : 4'hF;
        tests++;
        if (io.led !== e || io.busy !== (k < RUN)) begin
          failed++;
          $display("FAIL pattern m=%0d k=%0d led=%b busy=%b expected led=%b busy=%b", m, k, io.led, io.busy, e, k < RUN);
        end
      end
    end
  endtask
  task automatic test_debounce();
    io.mode = 2'($urandom);
    for (int i = 0; i < 50; i++) begin
      io.btn = i < 30 ? 1'((i / 2) % 2) : 1'b1;
      tick();
      tests++;
      if (io.busy !== 1'b0 || io.led !== 4'hF) begin
        failed++;
        $display("FAIL debounce_toggle i=%0d led=%b busy=%b expected led=1111 busy=0", i, io.led, io.busy);
      end
    end
    for (int g = 0; g < 15; g++) begin
      int lo, hi;
      lo = int'($urandom_range(1, DB - 1));
      hi = int'($urandom_range(1, 3));
      for (int j = 0; j < lo + hi; j++) begin
        io.btn = j < lo ? 1'b0 : 1'b1;
        tick();
        tests++;
        if (io.busy !== 1'b0) begin
          failed++;
          $display("FAIL debounce_glitch g=%0d lo=%0d busy=%b expected 0", g, lo, io.busy);
        end
      end
    end
    io.btn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if (io.busy !== 1'b0) begin
        failed++;
        $display("FAIL debounce_rest i=%0d busy=%b expected 0", i, io.busy);
      end
    end
  endtask
  task automatic test_retrigger();
    logic [N-1:0] e;
    press(0);
    io.btn = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      if (k == 25) begin
        io.mode = 2'd1;
        io.btn = 1'b0;
      end
      tick();
      tests++;
      if (io.led !== exp_led(0, k) || io.busy !== 1'b1) begin
        failed++;
        $display("FAIL retrig_pre k=%0d led=%b busy=%b expected led=%b busy=1", k, io.led, io.busy, exp_led(0, k));
      end
    end
    tick();
    tests++;
    if (io.led !== 4'b1110 || io.busy !== 1'b1) begin
      failed++;
      $display("FAIL retrig_entry led=%b busy=%b expected led=1110 busy=1", io.led, io.busy);
    end
    io.btn = 1'b1;
    for (int k = 1; k <= 39; k++) begin
      if (k == 33) begin
        io.mode = 2'd3;
        io.btn = 1'b0;
      end
      tick();
      tests++;
      if (io.led !== exp_led(1, k) || io.busy !== 1'b1) begin
        failed++;
        $display("FAIL retrig_chase k=%0d led=%b busy=%b expected led=%b busy=1", k, io.led, io.busy, exp_led(1, k));
      end
    end
    tick();
    tests++;
    if (io.led !== 4'hF || io.busy !== 1'b1) begin
      failed++;
      $display("FAIL retrig_vs_end led=%b busy=%b expected led=1111 busy=1", io.led, io.busy);
    end
    io.btn = 1'b1;
    for (int k = 1; k <= RUN + 3; k++) begin
      tick();
      e = k < RUN ? exp_led(3, k) : 4'hF;
      tests++;
      if (io.led !== e || io.busy !== (k < RUN)) begin
        failed++;
        $display("FAIL retrig_count k=%0d led=%b busy=%b expected led=%b busy=%b", k, io.led, io.busy, e, k < RUN);
      end
    end
  endtask
  task automatic test_async_reset();
    press(1);
    io.btn = 1'b1;
    repeat (12) tick();
    tests++;
    if (io.led !== exp_led(1, 12)) begin
      failed++;
      $display("FAIL pre_reset led=%b expected %b", io.led, exp_led(1, 12));
    end
    #3 reset = 1'b1;
    #1;
    tests++;
    if (io.led !== 4'hF || io.busy !== 1'b1) begin
      failed++;
      $display("FAIL async_reset led=%b busy=%b expected led=1111 busy=1", io.led, io.busy);
    end
    tick();
    tick();
    reset = 1'b0;
    for (int k = 1; k <= INIT + 3; k++) begin
      tick();
      tests++;
      if (io.led !== 4'hF || io.busy !== (k < INIT)) begin
        failed++;
        $display("FAIL reinit k=%0d led=%b busy=%b expected led=1111 busy=%b", k, io.led, io.busy, k < INIT);
      end
    end
  endtask
  initial begin
    #200000;
    failed++;
    $display("FAIL watchdog time=%0t expected finish earlier", $time);
    $fatal(1, "watchdog expired");
  end
  initial begin
    test_reset();
    test_press_latency();
    test_patterns();
    test_debounce();
    test_retrigger();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
